// File: rtl/anton_neopixel_stream_rx.sv
// NeoPixel serial receiver: synchronizes the line, decodes pulse widths into 24/32-bit pixels.
// Optional macro ANTON_NEOPIXEL_RX_32BIT_EN enables runtime 24/32-bit pixel width selection.
module anton_neopixel_stream_rx #(
  parameter int unsigned RESET_LOW_CYCLES  = 350,
  parameter int unsigned BIT_ONE_THRESHOLD = 4,
  parameter int unsigned HIGH_MAX          = 8
) (
  input  logic        clk7mhz,
  input  logic        rst,
  input  logic        stream_in,
  input  logic        reg_ctrl_32bit,
  output logic [31:0] pixel_data,
  output logic [7:0]  pixel_index,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        frame_end,
  output logic        err_overrun,
  output logic        err_long,
  output logic        err_partial
);

  localparam int unsigned LOW_W = $clog2(RESET_LOW_CYCLES + 1);
  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  logic             r_sync1, r_s, r_s_d;
  logic [1:0]       r_state;
  logic [LOW_W-1:0] r_low_cnt;
  logic [3:0]       r_high_cnt;
  logic [5:0]       r_bit_cnt;
  logic [30:0]      r_shift;
  logic             r_bits_seen;
  logic [7:0]       r_pix_cnt;

  logic [1:0]       w_state_nxt;
  logic [LOW_W-1:0] w_low_nxt, w_low_inc;
  logic [3:0]       w_high_nxt, w_high_inc;
  logic [5:0]       w_bit_nxt, w_bit_inc, w_width;
  logic [30:0]      w_shift_nxt;
  logic [31:0]      w_shift_new, w_pix_word;
  logic             w_seen_nxt, w_deliver, w_long_nxt, w_frame_nxt, w_partial_nxt;
  logic [7:0]       w_pix_nxt;
  logic             w_rise, w_gap, w_bit;

`ifdef ANTON_NEOPIXEL_RX_32BIT_EN
  logic r_mode32;
  assign w_width = r_mode32 ? 6'd32 : 6'd24;
`else
  logic w_unused_ctrl;
  assign w_unused_ctrl = reg_ctrl_32bit;
  assign w_width       = 6'd24;
`endif

  assign w_rise      = r_s & ~r_s_d;
  assign w_low_inc   = r_low_cnt + LOW_W'(1);
  assign w_gap       = (w_low_inc == LOW_W'(RESET_LOW_CYCLES));
  assign w_high_inc  = (r_high_cnt == 4'hF) ? 4'hF : r_high_cnt + 4'd1;
  assign w_bit       = (r_high_cnt >= 4'(BIT_ONE_THRESHOLD));
  assign w_shift_new = {r_shift, w_bit};
  assign w_bit_inc   = r_bit_cnt + 6'd1;
  assign w_pix_word  = (w_width == 6'd32) ? w_shift_new : {8'h00, w_shift_new[23:0]};

  // Next-state and decode logic
  always_comb begin
    w_state_nxt   = r_state;
    w_low_nxt     = r_low_cnt;
    w_high_nxt    = r_high_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_seen_nxt    = r_bits_seen;
    w_pix_nxt     = r_pix_cnt;
    w_deliver     = 1'b0;
    w_long_nxt    = 1'b0;
    w_frame_nxt   = 1'b0;
    w_partial_nxt = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (r_s) begin
          w_low_nxt = '0;
        end else if (w_gap) begin
          w_state_nxt = ST_IDLE;
          w_low_nxt   = '0;
          w_pix_nxt   = 8'd0;
        end else begin
          w_low_nxt = w_low_inc;
        end
      end
      ST_IDLE: begin
        w_low_nxt = '0;
        if (w_rise) begin
          w_state_nxt = ST_HIGH;
          w_high_nxt  = 4'd1;
        end
      end
      ST_HIGH: begin
        if (r_s) begin
          if (w_high_inc >= 4'(HIGH_MAX)) begin
            w_long_nxt  = 1'b1;
            w_state_nxt = ST_SYNC;
            w_high_nxt  = 4'd0;
            w_bit_nxt   = 6'd0;
            w_shift_nxt = '0;
            w_seen_nxt  = 1'b0;
            w_low_nxt   = '0;
          end else begin
            w_high_nxt = w_high_inc;
          end
        end else begin
          w_state_nxt = ST_LOW;
          w_low_nxt   = LOW_W'(1);
          w_high_nxt  = 4'd0;
          w_seen_nxt  = 1'b1;
          if (w_bit_inc == w_width) begin
            w_bit_nxt   = 6'd0;
            w_shift_nxt = '0;
            w_deliver   = 1'b1;
            w_pix_nxt   = r_pix_cnt + 8'd1;
          end else begin
            w_bit_nxt   = w_bit_inc;
            w_shift_nxt = w_shift_new[30:0];
          end
        end
      end
      default: begin
        if (r_s) begin
          w_state_nxt = ST_HIGH;
          w_high_nxt  = 4'd1;
          w_low_nxt   = '0;
        end else if (w_gap) begin
          w_state_nxt   = ST_IDLE;
          w_low_nxt     = '0;
          w_frame_nxt   = r_bits_seen;
          w_partial_nxt = (r_bit_cnt != 6'd0);
          w_bit_nxt     = 6'd0;
          w_shift_nxt   = '0;
          w_seen_nxt    = 1'b0;
          w_pix_nxt     = 8'd0;
        end else begin
          w_low_nxt = w_low_inc;
        end
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk7mhz) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_s         <= 1'b0;
      r_s_d       <= 1'b0;
      r_state     <= ST_SYNC;
      r_low_cnt   <= '0;
      r_high_cnt  <= 4'd0;
      r_bit_cnt   <= 6'd0;
      r_shift     <= '0;
      r_bits_seen <= 1'b0;
      r_pix_cnt   <= 8'd0;
      pixel_data  <= 32'd0;
      pixel_index <= 8'd0;
      pixel_valid <= 1'b0;
      frame_end   <= 1'b0;
      err_overrun <= 1'b0;
      err_long    <= 1'b0;
      err_partial <= 1'b0;
`ifdef ANTON_NEOPIXEL_RX_32BIT_EN
      r_mode32    <= 1'b0;
`endif
    end else begin
      r_sync1     <= stream_in;
      r_s         <= r_sync1;
      r_s_d       <= r_s;
      r_state     <= w_state_nxt;
      r_low_cnt   <= w_low_nxt;
      r_high_cnt  <= w_high_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_bits_seen <= w_seen_nxt;
      r_pix_cnt   <= w_pix_nxt;
      frame_end   <= w_frame_nxt;
      err_long    <= w_long_nxt;
      err_partial <= w_partial_nxt;
      err_overrun <= 1'b0;
`ifdef ANTON_NEOPIXEL_RX_32BIT_EN
      if (r_bit_cnt == 6'd0) r_mode32 <= reg_ctrl_32bit;
`endif
      // A held, unaccepted pixel wins; the newcomer is dropped but still indexed
      if (w_deliver) begin
        if (!pixel_valid || pixel_ready) begin
          pixel_data  <= w_pix_word;
          pixel_index <= r_pix_cnt;
          pixel_valid <= 1'b1;
        end else begin
          err_overrun <= 1'b1;
        end
      end else if (pixel_valid && pixel_ready) begin
        pixel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_anton_neopixel_stream_rx.sv
// Scoreboard bench for anton_neopixel_stream_rx; covers 32-bit mode when ANTON_NEOPIXEL_RX_32BIT_EN is defined.
module tb_anton_neopixel_stream_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stream_in = 1'b0;
  logic        reg_ctrl_32bit = 1'b0;
  logic        pixel_ready = 1'b1;
  logic [31:0] pixel_data;
  logic [7:0]  pixel_index;
  logic        pixel_valid, frame_end, err_overrun, err_long, err_partial;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt_frame, cnt_partial, cnt_fp, cnt_over, cnt_long;

  anton_neopixel_stream_rx dut (
    .clk7mhz        (clk),
    .rst            (rst),
    .stream_in      (stream_in),
    .reg_ctrl_32bit (reg_ctrl_32bit),
    .pixel_data     (pixel_data),
    .pixel_index    (pixel_index),
    .pixel_valid    (pixel_valid),
    .pixel_ready    (pixel_ready),
    .frame_end      (frame_end),
    .err_overrun    (err_overrun),
    .err_long       (err_long),
    .err_partial    (err_partial)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counters and scoreboard pop on handshake, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_end)                cnt_frame++;
      if (err_partial)              cnt_partial++;
      if (frame_end && err_partial) cnt_fp++;
      if (err_overrun)              cnt_over++;
      if (err_long)                 cnt_long++;
      if (pixel_valid && pixel_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pixel", 64'(pixel_data), 64'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pix_data", 64'(pixel_data), 64'(e.data));
          check("pix_index", 64'(pixel_index), 64'(e.idx));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    cnt_frame = 0; cnt_partial = 0; cnt_fp = 0; cnt_over = 0; cnt_long = 0;
  endtask

  task automatic drive_low(input int n);
    stream_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse(input int h);
    stream_in = 1'b1;
    repeat (h) tick();
    stream_in = 1'b0;
    repeat (8 - h) tick();
  endtask

  task automatic send_word(input logic [31:0] v, input int nbits, input int h1, input int h0);
    for (int i = nbits - 1; i >= 0; i--) pulse(v[i] ? h1 : h0);
  endtask

  task automatic push(input logic [31:0] d, input logic [7:0] idx);
    exp_t e;
    e.data = d;
    e.idx  = idx;
    sb.push_back(e);
  endtask

  initial begin
    logic [31:0] d0, d1, d2, d3;
    clr_counts();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_data", 64'(pixel_data), 64'h0);
    check("rst_index", 64'(pixel_index), 64'h0);
    check("rst_valid", 64'(pixel_valid), 64'h0);
    check("rst_pulses", 64'({frame_end, err_overrun, err_long, err_partial}), 64'h0);
    rst = 1'b0;

    // Basic pixel, then two more in the same frame
    pixel_ready = 1'b1;
    drive_low(360);
    push(32'h00A5C33C, 8'd0);
    send_word(32'h00A5C33C, 24, 5, 2);
    drive_low(10);
    check("t1_drain", 64'(sb.size()), 64'd0);
    d0 = 32'($urandom) & 32'h00FFFFFF;
    d1 = 32'($urandom) & 32'h00FFFFFF;
    push(d0, 8'd1);
    send_word(d0, 24, 5, 2);
    push(d1, 8'd2);
    send_word(d1, 24, 5, 2);
    drive_low(10);
    clr_counts();
    drive_low(360);
    check("t1_frame_end", 64'(cnt_frame), 64'd1);
    check("t1_no_partial", 64'(cnt_partial), 64'd0);

    // Threshold boundaries: 4 high = 1, 3 high = 0, 7 high still valid
    clr_counts();
    push(32'h005A0F96, 8'd0);
    send_word(32'h005A0F96, 24, 4, 3);
    push(32'h00FFFFFF, 8'd1);
    send_word(32'h00FFFFFF, 24, 7, 2);
    drive_low(10);
    check("thr_drain", 64'(sb.size()), 64'd0);
    check("thr_no_long", 64'(cnt_long), 64'd0);
    drive_low(360);

    // Overrun: three pixels while consumer stalls
    pixel_ready = 1'b0;
    clr_counts();
    d0 = 32'h00123456; d1 = 32'h00ABCDEF; d2 = 32'h00F0F0F0; d3 = 32'h000F0F0F;
    send_word(d0, 24, 5, 2);
    send_word(d1, 24, 5, 2);
    send_word(d2, 24, 5, 2);
    drive_low(10);
    check("ovr_valid", 64'(pixel_valid), 64'd1);
    check("ovr_held_data", 64'(pixel_data), 64'(d0));
    check("ovr_held_index", 64'(pixel_index), 64'd0);
    check("ovr_count", 64'(cnt_over), 64'd2);
    push(d0, 8'd0);
    pixel_ready = 1'b1;
    drive_low(3);
    check("ovr_valid_cleared", 64'(pixel_valid), 64'd0);
    push(d3, 8'd3);
    send_word(d3, 24, 5, 2);
    drive_low(10);
    check("ovr_drain", 64'(sb.size()), 64'd0);
    drive_low(360);
    check("ovr_frame_end", 64'(cnt_frame), 64'd1);

    // Partial pixel then gap
    clr_counts();
    send_word(32'h00000ABC, 12, 5, 2);
    drive_low(360);
    check("part_frame_end", 64'(cnt_frame), 64'd1);
    check("part_err", 64'(cnt_partial), 64'd1);
    check("part_same_cycle", 64'(cnt_fp), 64'd1);
    check("part_no_valid", 64'(pixel_valid), 64'd0);

    // Stuck-high pulse: exactly 8 high cycles, then resync required
    clr_counts();
    stream_in = 1'b1;
    repeat (8) tick();
    drive_low(20);
    check("long_err", 64'(cnt_long), 64'd1);
    send_word(32'h00777777, 24, 5, 2);
    drive_low(20);
    check("long_ignored", 64'(pixel_valid), 64'd0);
    drive_low(360);
    check("long_no_frame_end", 64'(cnt_frame), 64'd0);
    push(32'h00C3A501, 8'd0);
    send_word(32'h00C3A501, 24, 5, 2);
    drive_low(10);
    check("long_recover_drain", 64'(sb.size()), 64'd0);
    drive_low(360);

    // Reset in the middle of a pixel while another is held
    clr_counts();
    pixel_ready = 1'b0;
    send_word(32'h00BEEF01, 24, 5, 2);
    drive_low(5);
    check("rst_pre_valid", 64'(pixel_valid), 64'd1);
    send_word(32'h00000155, 10, 5, 2);
    rst = 1'b1;
    tick();
    check("rst_mid_data", 64'(pixel_data), 64'h0);
    check("rst_mid_valid", 64'(pixel_valid), 64'h0);
    check("rst_mid_index", 64'(pixel_index), 64'h0);
    rst = 1'b0;
    send_word(32'h00003FFF, 14, 5, 2);
    drive_low(20);
    check("rst_no_pixel", 64'(pixel_valid), 64'd0);
    check("rst_no_errs", 64'({cnt_over, cnt_long, cnt_partial, cnt_frame}), 64'd0);
    pixel_ready = 1'b1;
    drive_low(360);
    push(32'h00010203, 8'd0);
    send_word(32'h00010203, 24, 5, 2);
    drive_low(10);
    drive_low(360);

`ifdef ANTON_NEOPIXEL_RX_32BIT_EN
    reg_ctrl_32bit = 1'b1;
    tick();
    push(32'h11223344, 8'd0);
    send_word(32'h11223344, 32, 5, 2);
    drive_low(4);
    reg_ctrl_32bit = 1'b0;
    drive_low(4);
    push(32'h00556677, 8'd1);
    send_word(32'h00556677, 24, 5, 2);
`else
    reg_ctrl_32bit = 1'b1;
    tick();
    push(32'h00C0FFEE, 8'd0);
    send_word(32'h00C0FFEE, 24, 5, 2);
`endif
    drive_low(10);
    check("final_drain", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
